fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 132 +++++++++++++
 tb/tb_fetch_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch front end.
// Walks a fetch PC through a combinational-read instruction ROM and buffers
// {pc, instr} pairs in a 2-entry FIFO that feeds decode through a
// valid/ready handshake. A redirect flushes the FIFO and reloads the PC.
// Fetching stops (HALT) once the PC reaches PC_LIMIT. Only an in-range
// redirect leaves HALT.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT = 32'd1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  // FIFO storage: the head entry drives out_*, and the tail is the second slot.
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic [31:0] tail_pc_q, tail_pc_d;
  logic [31:0] tail_instr_q, tail_instr_d;

  logic        pop;
  logic        push;
  logic [31:0] redirect_pc;

  // Handshake and fetch qualification for this cycle.
  always_comb begin
    pop         = (count_q != 2'd0) && out_ready;
    push        = (state_q != ST_HALT) && (pc_q < PC_LIMIT) && !redirect_valid
                  && ((count_q != 2'd2) || pop);
    redirect_pc = redirect_target & ~32'h0000_0003;
  end

  // Next-state logic for the PC, the FIFO contents and the FSM. Redirect takes priority over push and pop.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;

    if (redirect_valid) begin
      count_d = 2'd0;
      pc_d    = redirect_pc;
      state_d = (redirect_pc >= PC_LIMIT) ? ST_HALT : ST_FETCH;
    end else begin
      if (push) begin
        pc_d = pc_q + 32'd4;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};

      // The head takes the new word when the FIFO is, or is about to become, empty.
      // Otherwise a pop moves the tail up.
      if (push && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
        head_pc_d    = pc_q;
        head_instr_d = imem_data;
      end else if (pop) begin
        head_pc_d    = tail_pc_q;
        head_instr_d = tail_instr_q;
      end

      // The tail takes the new word when it lands behind a live head.
      if (push && (((count_q == 2'd1) && !pop) || ((count_q == 2'd2) && pop))) begin
        tail_pc_d    = pc_q;
        tail_instr_d = imem_data;
      end

      if (state_q == ST_HALT) begin
        state_d = ST_HALT;
      end else if (pc_d >= PC_LIMIT) begin
        state_d = ST_HALT;
      end else if ((count_d == 2'd2) && !pop) begin
        state_d = ST_STALL;
      end else begin
        state_d = ST_FETCH;
      end
    end
  end

  // State register with synchronous reset. Reset overrides redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      count_q      <= 2'd0;
      // NOTE: the FIFO data slots are cleared as well, not only the count,
      // because out_pc/out_instr must read zero while in reset.
      head_pc_q    <= 32'd0;
      head_instr_q <= 32'd0;
      tail_pc_q    <= 32'd0;
      tail_instr_q <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // values, so the order of these lines does not matter.
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = head_pc_q;
  assign out_instr = head_instr_q;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed test of fetch_ctrl with a scoreboard.
// Stimulus code queues each {pc, instr} that decode should accept. A
// negedge monitor pops and compares on every accepted transfer. Inline
// checks cover reset values, stall, redirect and halt timing.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_LIMIT = 32'd1024;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } xfer_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halted;

  int    n_tests = 0;
  int    n_fail  = 0;
  xfer_t exp_q[$];
  logic [31:0] rom [256];

  fetch_ctrl #(.RESET_PC(RESET_PC), .PC_LIMIT(PC_LIMIT)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Combinational ROM read.
  assign imem_data = rom[imem_addr[9:2]];

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'hC0DE_0000 | {22'd0, pc[9:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [31:0] pc);
    xfer_t x;
    x.pc    = pc;
    x.instr = rom_word(pc);
    exp_q.push_back(x);
  endtask

  // Reset for two cycles and check the reset values. On return, reset is released and the bench is in the first cycle after release.
  task automatic do_reset();
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    out_ready       = 1'b0;
    step();
    step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: one comparison per accepted transfer.
  always @(negedge clk) begin
    if (!reset && !redirect_valid && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_xfer", out_pc, 32'hFFFF_FFFF);
      end else begin
        xfer_t x;
        x = exp_q.pop_front();
        check("sb_pc", out_pc, x.pc);
        check("sb_instr", out_instr, x.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = rom_word(32'(i) << 2);

    // Test 1: from reset, with out_ready held high, one instruction per cycle.
    do_reset();
    check("t1_first_addr", imem_addr, RESET_PC);
    check("t1_first_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) exp_push(32'(i) << 2);
    step();
    check("t1_second_pc", out_pc, RESET_PC);
    for (int i = 0; i < 20; i++) begin
      check("t1_thru_valid", {31'd0, out_valid}, 32'd1);
      step();
    end
    out_ready = 1'b0;
    check("t1_sb_drained", exp_q.size(), 32'd0);

    // Test 2: hold out_ready low so the FIFO fills, then release it.
    do_reset();
    step();                                   // cycle 2: first valid
    check("t2_first_pc", out_pc, 32'd0);
    for (int i = 0; i < 4; i++) step();       // cycles 3..6 with out_ready low
    check("t2_stall_addr", imem_addr, 32'd8);
    check("t2_stall_pc", out_pc, 32'd0);
    check("t2_stall_valid", {31'd0, out_valid}, 32'd1);
    step();                                   // cycle 7
    exp_push(32'd0);
    exp_push(32'd4);
    exp_push(32'd8);
    out_ready = 1'b1;
    check("t2_rel_valid0", {31'd0, out_valid}, 32'd1);
    step();
    check("t2_rel_valid1", {31'd0, out_valid}, 32'd1);
    check("t2_rel_pc1", out_pc, 32'd4);
    step();
    check("t2_rel_valid2", {31'd0, out_valid}, 32'd1);
    check("t2_rel_pc2", out_pc, 32'd8);
    step();                                   // cycle 10: {12,16} buffered

    // Test 3: a redirect with two entries buffered discards the head even though out_ready is high.
    check("t3_pre_pc", out_pc, 32'd12);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_004C;
    step();
    redirect_valid = 1'b0;
    check("t3_flush_valid", {31'd0, out_valid}, 32'd0);
    check("t3_flush_addr", imem_addr, 32'h4C);
    exp_push(32'h4C);
    step();
    check("t3_tgt_valid", {31'd0, out_valid}, 32'd1);
    check("t3_tgt_pc", out_pc, 32'h4C);
    check("t3_tgt_instr", out_instr, rom_word(32'h4C));
    step();
    out_ready = 1'b0;

    // Test 4: unaligned target, out-of-range target (HALT), then return to 0.
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_004E;
    step();
    redirect_valid = 1'b0;
    check("t4_align_addr", imem_addr, 32'h4C);
    check("t4_align_valid", {31'd0, out_valid}, 32'd0);
    step();
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0400;
    step();
    redirect_valid = 1'b0;
    check("t4_halt", {31'd0, halted}, 32'd1);
    check("t4_halt_addr", imem_addr, 32'h400);
    check("t4_halt_valid", {31'd0, out_valid}, 32'd0);
    step();
    step();
    check("t4_halt_hold", {31'd0, halted}, 32'd1);
    check("t4_halt_frozen", imem_addr, 32'h400);
    check("t4_halt_novalid", {31'd0, out_valid}, 32'd0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0000;
    step();
    redirect_valid = 1'b0;
    check("t4_resume_halted", {31'd0, halted}, 32'd0);
    check("t4_resume_addr", imem_addr, 32'd0);
    out_ready = 1'b1;
    exp_push(32'd0);
    step();
    check("t4_resume_valid", {31'd0, out_valid}, 32'd1);
    check("t4_resume_pc", out_pc, 32'd0);
    step();
    out_ready = 1'b0;
    check("t4_sb_drained", exp_q.size(), 32'd0);

    // Test 5: free-run to the end of the ROM. Enter HALT with two entries buffered, then drain them.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) exp_push(32'(i) << 2);
    step();                                   // cycle 2
    for (int i = 0; i < 254; i++) begin
      check("t5_thru_valid", {31'd0, out_valid}, 32'd1);
      step();
    end
    out_ready = 1'b0;                         // cycle 256: head 0x3F8
    check("t5_pre_halt", {31'd0, halted}, 32'd0);
    check("t5_pre_pc", out_pc, 32'h3F8);
    step();
    check("t5_halted", {31'd0, halted}, 32'd1);
    check("t5_halt_valid", {31'd0, out_valid}, 32'd1);
    check("t5_halt_addr", imem_addr, 32'h400);
    check("t5_halt_pc", out_pc, 32'h3F8);
    step();
    check("t5_hold_pc", out_pc, 32'h3F8);
    check("t5_hold_instr", out_instr, rom_word(32'h3F8));
    out_ready = 1'b1;
    step();
    check("t5_last_pc", out_pc, 32'h3FC);
    step();
    out_ready = 1'b0;
    check("t5_drained_valid", {31'd0, out_valid}, 32'd0);
    check("t5_drained_halted", {31'd0, halted}, 32'd1);
    check("t5_sb_drained", exp_q.size(), 32'd0);

    // Test 6: reset asserted together with a redirect while the FIFO is full.
    do_reset();
    step();
    step();
    check("t6_full_addr", imem_addr, 32'd8);
    reset           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0100;
    step();
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_addr", imem_addr, RESET_PC);
    check("t6_rst_halted", {31'd0, halted}, 32'd0);
    check("t6_rst_pc", out_pc, 32'd0);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    step();
    check("t6_after_valid", {31'd0, out_valid}, 32'd1);
    check("t6_after_pc", out_pc, RESET_PC);
    check("t6_sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
